// File: rtl/button_conditioner.sv
// Conditions raw board buttons: 2-FF sync, counter debounce, press/release pulses,
// typematic auto-repeat and frame-aligned sticky press flags.
module button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 360000,
  parameter int REPEAT_DELAY    = 18000000,
  parameter int REPEAT_PERIOD   = 3600000
) (
  input  logic             pixel_clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             frame_tick,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [N_BTN-1:0] btn_frame_evt
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX);

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE     = DW'(1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] RCNT_ONE    = RW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  logic [N_BTN-1:0] sync1_r;
  logic [N_BTN-1:0] sync2_r;
  logic [DW-1:0]    deb_cnt_r [N_BTN];
  logic [N_BTN-1:0] accept_s;
  logic [N_BTN-1:0] rise_s;
  logic [N_BTN-1:0] fall_s;

  rpt_state_t       state_r      [N_BTN];
  rpt_state_t       state_next_s [N_BTN];
  logic [RW-1:0]    rcnt_r       [N_BTN];
  logic [RW-1:0]    rcnt_next_s  [N_BTN];
  logic [N_BTN-1:0] rpt_pulse_s;

  logic [N_BTN-1:0] sticky_r;

  // Debounce decision: a change is accepted on the last counted cycle of disagreement.
  always_comb begin
    accept_s = '0;
    rise_s   = '0;
    fall_s   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      accept_s[i] = (sync2_r[i] != btn_level[i]) && (deb_cnt_r[i] == DEB_LAST);
      rise_s[i]   = accept_s[i] & sync2_r[i];
      fall_s[i]   = accept_s[i] & ~sync2_r[i];
    end
  end

  // Synchronizer, debounce counters, level and edge pulses.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      sync1_r     <= '0;
      sync2_r     <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt_r[i] <= '0;
      end
    end else begin
      sync1_r     <= btn_raw;
      sync2_r     <= sync1_r;
      btn_press   <= rise_s;
      btn_release <= fall_s;
      for (int i = 0; i < N_BTN; i++) begin
        if (accept_s[i]) begin
          btn_level[i] <= sync2_r[i];
          deb_cnt_r[i] <= '0;
        end else if (sync2_r[i] != btn_level[i]) begin
          btn_level[i] <= btn_level[i];
          deb_cnt_r[i] <= deb_cnt_r[i] + DEB_ONE;
        end else begin
          btn_level[i] <= btn_level[i];
          deb_cnt_r[i] <= '0;
        end
      end
    end
  end

  // Auto-repeat next state; a release overrides any pending pulse in the same cycle.
  always_comb begin
    state_next_s = state_r;
    rcnt_next_s  = rcnt_r;
    rpt_pulse_s  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (fall_s[i]) begin
        state_next_s[i] = ST_IDLE;
        rcnt_next_s[i]  = '0;
      end else begin
        case (state_r[i])
          ST_IDLE: begin
            if (rise_s[i]) begin
              state_next_s[i] = ST_DELAY;
              rcnt_next_s[i]  = '0;
              rpt_pulse_s[i]  = 1'b1;
            end else begin
              state_next_s[i] = ST_IDLE;
              rcnt_next_s[i]  = '0;
            end
          end
          ST_DELAY: begin
            if (rcnt_r[i] == DELAY_LAST) begin
              state_next_s[i] = ST_REPEAT;
              rcnt_next_s[i]  = '0;
              rpt_pulse_s[i]  = 1'b1;
            end else begin
              state_next_s[i] = ST_DELAY;
              rcnt_next_s[i]  = rcnt_r[i] + RCNT_ONE;
            end
          end
          ST_REPEAT: begin
            if (rcnt_r[i] == PERIOD_LAST) begin
              state_next_s[i] = ST_REPEAT;
              rcnt_next_s[i]  = '0;
              rpt_pulse_s[i]  = 1'b1;
            end else begin
              state_next_s[i] = ST_REPEAT;
              rcnt_next_s[i]  = rcnt_r[i] + RCNT_ONE;
            end
          end
          default: begin
            state_next_s[i] = ST_IDLE;
            rcnt_next_s[i]  = '0;
          end
        endcase
      end
    end
  end

  // Auto-repeat state register and registered repeat pulse.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      btn_repeat <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state_r[i] <= ST_IDLE;
        rcnt_r[i]  <= '0;
      end
    end else begin
      btn_repeat <= rpt_pulse_s;
      state_r    <= state_next_s;
      rcnt_r     <= rcnt_next_s;
    end
  end

  // Frame sticky: a press coincident with frame_tick goes straight into this frame's flags.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      sticky_r      <= '0;
      btn_frame_evt <= '0;
    end else if (frame_tick) begin
      btn_frame_evt <= sticky_r | btn_press;
      sticky_r      <= '0;
    end else begin
      btn_frame_evt <= btn_frame_evt;
      sticky_r      <= sticky_r | btn_press;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: per-cycle comparison against a
// cycle-age behavioural model, plus directed literal expectations.
module tb_button_conditioner;

  localparam int NB = 5;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          pixel_clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic          frame_tick;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_repeat;
  logic [NB-1:0] btn_frame_evt;

  int n_vec = 0;
  int n_err = 0;

  button_conditioner #(
    .N_BTN          (NB),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .pixel_clk    (pixel_clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .frame_tick   (frame_tick),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .btn_release  (btn_release),
    .btn_repeat   (btn_repeat),
    .btn_frame_evt(btn_frame_evt)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a button is accepted after D consecutive disagreeing samples
  // of the 2-cycle-delayed raw input; repeats are a function of cycles since press.
  logic [NB-1:0] m_s1, m_s2, m_level, m_press, m_release, m_repeat, m_sticky, m_evt;
  int            m_run [NB];
  int            m_age [NB];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_release = '0;
    m_repeat = '0; m_sticky = '0; m_evt = '0;
    for (int i = 0; i < NB; i++) begin
      m_run[i] = 0;
      m_age[i] = -1;
    end
  endtask

  task automatic model_step();
    logic [NB-1:0] np, nr, nq;
    np = '0; nr = '0; nq = '0;
    if (frame_tick) begin
      m_evt    = m_sticky | m_press;
      m_sticky = '0;
    end else begin
      m_sticky = m_sticky | m_press;
    end
    for (int i = 0; i < NB; i++) begin
      if (m_s2[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_run[i]   = 0;
          np[i]      = m_s2[i];
          nr[i]      = ~m_s2[i];
          m_level[i] = m_s2[i];
        end
      end else begin
        m_run[i] = 0;
      end
      if (np[i]) m_age[i] = 0;
      else if (nr[i]) m_age[i] = -1;
      else if (m_age[i] >= 0) m_age[i]++;
      nq[i] = np[i] || (m_age[i] == RD) || (m_age[i] > RD && ((m_age[i] - RD) % RP) == 0);
    end
    m_s2 = m_s1;
    m_s1 = btn_raw;
    m_press = np; m_release = nr; m_repeat = nq;
  endtask

  // Compare process: model advances on every edge (or async reset), DUT checked 1 ns later.
  always @(posedge pixel_clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
    #1;
    chk("cmp_level",   btn_level,     m_level);
    chk("cmp_press",   btn_press,     m_press);
    chk("cmp_release", btn_release,   m_release);
    chk("cmp_repeat",  btn_repeat,    m_repeat);
    chk("cmp_evt",     btn_frame_evt, m_evt);
  end

  initial begin
    rst = 1'b1; btn_raw = 5'h1F; frame_tick = 1'b0;

    // 1: reset with all buttons held, then release reset
    repeat (3) @(negedge pixel_clk);
    chk("rst_level", btn_level, 5'h00);
    chk("rst_press", btn_press, 5'h00);
    chk("rst_rel",   btn_release, 5'h00);
    chk("rst_rep",   btn_repeat, 5'h00);
    chk("rst_evt",   btn_frame_evt, 5'h00);
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge pixel_clk); #2;
      chk("t1_level", btn_level,  (e >= 6) ? 5'h1F : 5'h00);
      chk("t1_press", btn_press,  (e == 6) ? 5'h1F : 5'h00);
      chk("t1_rep",   btn_repeat, (e == 6) ? 5'h1F : 5'h00);
    end
    @(negedge pixel_clk);
    btn_raw = 5'h00;
    for (int e = 1; e <= 8; e++) begin
      @(posedge pixel_clk); #2;
      chk("t1_release", btn_release, (e == 6) ? 5'h1F : 5'h00);
    end
    @(negedge pixel_clk);

    // 2: 3-cycle glitch on bit 0 must be rejected
    btn_raw = 5'h01;
    for (int e = 1; e <= 12; e++) begin
      @(posedge pixel_clk); #2;
      chk("t2_level", btn_level,  5'h00);
      chk("t2_press", btn_press,  5'h00);
      chk("t2_rep",   btn_repeat, 5'h00);
      @(negedge pixel_clk);
      if (e == 3) btn_raw = 5'h00;
    end

    // 3: hold bit 2 for 40 cycles, then release
    btn_raw = 5'h04;
    for (int e = 1; e <= 40; e++) begin
      @(posedge pixel_clk); #2;
      chk("t3_press", btn_press, (e == 6) ? 5'h04 : 5'h00);
      chk("t3_rep",   btn_repeat,
          (e == 6 || (e >= 16 && ((e - 16) % 3) == 0)) ? 5'h04 : 5'h00);
    end
    @(negedge pixel_clk);
    btn_raw = 5'h00;
    for (int e = 1; e <= 10; e++) begin
      @(posedge pixel_clk); #2;
      chk("t3_release", btn_release, (e == 6) ? 5'h04 : 5'h00);
      chk("t3_rep_tail", btn_repeat, (e == 3) ? 5'h04 : 5'h00);
    end
    @(negedge pixel_clk);

    // 4: flush earlier presses, then mid-frame press on bit 1
    frame_tick = 1'b1;
    @(negedge pixel_clk);
    frame_tick = 1'b0;
    chk("t4_flush_evt", btn_frame_evt, 5'h1F);
    btn_raw = 5'h02;
    repeat (20) @(negedge pixel_clk);
    frame_tick = 1'b1;
    @(negedge pixel_clk);
    frame_tick = 1'b0;
    chk("t4_evt", btn_frame_evt, 5'h02);
    repeat (10) @(negedge pixel_clk);
    chk("t4_evt_hold", btn_frame_evt, 5'h02);
    frame_tick = 1'b1;
    @(negedge pixel_clk);
    frame_tick = 1'b0;
    chk("t4_evt_clear", btn_frame_evt, 5'h00);
    btn_raw = 5'h00;
    repeat (10) @(negedge pixel_clk);

    // 5: press on bit 3 coincident with frame_tick
    btn_raw = 5'h08;
    repeat (6) @(negedge pixel_clk);
    chk("t5_press", btn_press, 5'h08);
    frame_tick = 1'b1;
    @(negedge pixel_clk);
    frame_tick = 1'b0;
    chk("t5_evt", btn_frame_evt, 5'h08);
    repeat (5) @(negedge pixel_clk);
    frame_tick = 1'b1;
    @(negedge pixel_clk);
    frame_tick = 1'b0;
    chk("t5_evt_next", btn_frame_evt, 5'h00);

    // 6: asynchronous reset while bit 4 is auto-repeating
    btn_raw = 5'h10;
    repeat (20) @(negedge pixel_clk);
    chk("t6_level_pre", btn_level, 5'h10);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_level", btn_level, 5'h00);
    chk("t6_rst_press", btn_press, 5'h00);
    chk("t6_rst_rel",   btn_release, 5'h00);
    chk("t6_rst_rep",   btn_repeat, 5'h00);
    chk("t6_rst_evt",   btn_frame_evt, 5'h00);
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    rst = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge pixel_clk); #2;
      chk("t6_level", btn_level,  (e >= 6) ? 5'h10 : 5'h00);
      chk("t6_press", btn_press,  (e == 6) ? 5'h10 : 5'h00);
      chk("t6_rep",   btn_repeat, (e == 6 || e == 16 || e == 19) ? 5'h10 : 5'h00);
    end
    @(negedge pixel_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
